// File: rtl/ahb_gpio_pkg.sv
// Shared constants for the AHB GPIO block: width, register offsets and parity modes.
package ahb_gpio_pkg;

  localparam int         GPIO_W      = 16;

  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_DIR    = 8'h04;

  localparam logic       PARITY_EVEN = 1'b0;
  localparam logic       PARITY_ODD  = 1'b1;

endpackage

// File: rtl/ahb_gpio_parity.sv
// Parity bit for a GPIO word; makes data plus parity carry an odd or even count of ones.
module gpio_parity
  import ahb_gpio_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] data,
  input  logic              parity_sel,
  output logic              parity
);

  assign parity = (parity_sel == PARITY_ODD) ? ~^data : ^data;

endmodule

// File: rtl/ahb_gpio.sv
// AHB-Lite GPIO slave: DATA/DIR registers, parity on the output pads and parity check on the inputs.
module ahb_gpio
  import ahb_gpio_pkg::*;
#(
  parameter int GPIO_W = ahb_gpio_pkg::GPIO_W
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic              HREADY,
  output logic              HREADYOUT,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  input  logic [GPIO_W:0]   GPIOIN,
  output logic [GPIO_W:0]   GPIOOUT,
  input  logic              PARITYSEL,
  output logic              PARITYERR
);

  logic [7:0]        addr_p1;
  logic              write_p1;
  logic              vld_p1;
  logic              accept;
  logic              wr_data;
  logic              wr_dir;
  logic [GPIO_W-1:0] data_out;
  logic [GPIO_W-1:0] data_in;
  logic              out_parity;
  logic              dir;
  logic              parity_err;
  logic              par_gen;
  logic              par_chk;
  logic              unused_bits;

  assign unused_bits = ^{HADDR[31:8], HTRANS[0], HWDATA[31:GPIO_W]};

  assign HREADYOUT = 1'b1;
  assign accept    = HSEL & HREADY & HTRANS[1];

  // Address phase -> data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vld_p1   <= 1'b0;
      write_p1 <= 1'b0;
      addr_p1  <= 8'h00;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        write_p1 <= HWRITE;
        addr_p1  <= HADDR[7:0];
      end
    end
  end

  assign wr_data = vld_p1 & write_p1 & (addr_p1 == ADDR_DATA);
  assign wr_dir  = vld_p1 & write_p1 & (addr_p1 == ADDR_DIR);

  gpio_parity #(.DATA_W(GPIO_W)) u_par_gen (
    .data       (HWDATA[GPIO_W-1:0]),
    .parity_sel (PARITYSEL),
    .parity     (par_gen)
  );

  gpio_parity #(.DATA_W(GPIO_W)) u_par_chk (
    .data       (GPIOIN[GPIO_W-1:0]),
    .parity_sel (PARITYSEL),
    .parity     (par_chk)
  );

  // Data phase: register updates and pad sampling
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_out   <= '0;
      out_parity <= 1'b0;
      dir        <= 1'b0;
      data_in    <= '0;
      parity_err <= 1'b0;
    end else begin
      if (wr_data) begin
        data_out   <= HWDATA[GPIO_W-1:0];
        out_parity <= par_gen;
      end
      if (wr_dir)
        dir <= HWDATA[0];
      if (!dir) begin
        data_in    <= GPIOIN[GPIO_W-1:0];
        parity_err <= GPIOIN[GPIO_W] ^ par_chk;
      end else begin
        parity_err <= 1'b0;
      end
    end
  end

  assign GPIOOUT   = {out_parity, data_out};
  assign PARITYERR = parity_err;

  // Read data straight from the latched address so a read right after a write sees new data
  always_comb begin
    HRDATA = 32'h0;
    if (vld_p1 && !write_p1) begin
      case (addr_p1)
        ADDR_DATA: HRDATA = {{(32-GPIO_W){1'b0}}, (dir ? data_out : data_in)};
        ADDR_DIR:  HRDATA = {31'h0, dir};
        default:   HRDATA = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_gpio.sv
// Directed bench for ahb_gpio: register access, parity generation/check, loopback.
module tb_ahb_gpio;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic [16:0] GPIOIN;
  logic [16:0] GPIOOUT;
  logic        PARITYSEL;
  logic        PARITYERR;

  logic [16:0] gpio_in_drv;
  logic        loop_en;
  int          n_checks = 0;
  int          n_errors = 0;

  assign GPIOIN = loop_en ? GPIOOUT : gpio_in_drv;

  always #5 HCLK = ~HCLK;

  ahb_gpio #(.GPIO_W(16)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .GPIOIN    (GPIOIN),
    .GPIOOUT   (GPIOOUT),
    .PARITYSEL (PARITYSEL),
    .PARITYERR (PARITYERR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_par(input logic [15:0] d, input logic odd);
    logic ones_odd;
    ones_odd = ($countones(d) % 2) == 1;
    return odd ? ~ones_odd : ones_odd;
  endfunction

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HREADY = 1'b1;
  endtask

  // Address phase, data phase, then one more edge so the write has landed
  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d,
                           input logic sel = 1'b1, input logic [1:0] tr = 2'b10,
                           input logic rdy = 1'b1);
    @(negedge HCLK);
    HSEL   = sel;
    HTRANS = tr;
    HREADY = rdy;
    HWRITE = 1'b1;
    HADDR  = 32'h4000_0000 | {24'h0, a};
    @(negedge HCLK);
    bus_idle();
    HWDATA = d;
    @(negedge HCLK);
  endtask

  task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge HCLK);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    HADDR  = 32'h4000_0000 | {24'h0, a};
    @(negedge HCLK);
    bus_idle();
    d = HRDATA;
  endtask

  task automatic ahb_wr_rd(input logic [7:0] a, input logic [31:0] d, output logic [31:0] r);
    @(negedge HCLK);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HADDR  = {24'h0, a};
    @(negedge HCLK);
    HWDATA = d;
    HWRITE = 1'b0;
    @(negedge HCLK);
    bus_idle();
    r = HRDATA;
  endtask

  initial begin
    logic [31:0] rd;
    logic [15:0] d;
    logic        sel;

    bus_idle();
    HADDR       = 32'h0;
    HWDATA      = 32'h0;
    PARITYSEL   = 1'b0;
    gpio_in_drv = 17'h0;
    loop_en     = 1'b0;
    HRESETn     = 1'b0;
    repeat (2) @(negedge HCLK);
    check("rst_hreadyout", 32'(HREADYOUT), 32'h1);
    check("rst_gpioout", 32'(GPIOOUT), 32'h0);
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("rst_parityerr", 32'(PARITYERR), 32'h0);
    ahb_read(8'h00, rd); check("rst_rd_data", rd, 32'h0);
    ahb_read(8'h04, rd); check("rst_rd_dir", rd, 32'h0);
    check("idle_hrdata", HRDATA, 32'h0);

    // Output mode, even then odd parity
    ahb_write(8'h04, 32'h1);
    PARITYSEL = 1'b0;
    ahb_write(8'h00, 32'hFFFF_00A5);
    check("even_a5", 32'(GPIOOUT), 32'h000A5);
    PARITYSEL = 1'b1;
    ahb_write(8'h00, 32'h0000_00A5);
    check("odd_a5", 32'(GPIOOUT), 32'h100A5);
    ahb_read(8'h00, rd); check("rd_a5", rd, 32'h0000_00A5);
    ahb_read(8'h04, rd); check("rd_dir1", rd, 32'h1);

    ahb_wr_rd(8'h00, 32'h0000_1234, rd);
    check("b2b_rd", rd, 32'h0000_1234);
    check("b2b_out", 32'(GPIOOUT), 32'h01234);

    // Unmapped and unqualified transfers leave registers alone
    ahb_write(8'h08, 32'h0000_FFFF);
    ahb_read(8'h00, rd); check("unmap_data", rd, 32'h0000_1234);
    ahb_read(8'h04, rd); check("unmap_dir", rd, 32'h1);
    ahb_read(8'h08, rd); check("unmap_rd", rd, 32'h0);
    ahb_write(8'h00, 32'h5555, 1'b0);
    check("hsel0", 32'(GPIOOUT), 32'h01234);
    ahb_write(8'h00, 32'h5555, 1'b1, 2'b01);
    check("busy", 32'(GPIOOUT), 32'h01234);
    ahb_write(8'h00, 32'h5555, 1'b1, 2'b10, 1'b0);
    check("hready0", 32'(GPIOOUT), 32'h01234);
    ahb_write(8'h04, 32'h0, 1'b0);
    ahb_read(8'h04, rd); check("hsel0_dir", rd, 32'h1);

    // Input mode parity check
    ahb_write(8'h04, 32'h0);
    PARITYSEL   = 1'b0;
    gpio_in_drv = {1'b1, 16'h0001};
    @(negedge HCLK);
    check("in_even_ok", 32'(PARITYERR), 32'h0);
    ahb_read(8'h00, rd); check("rd_in", rd, 32'h0000_0001);
    gpio_in_drv = {1'b0, 16'h0001};
    @(negedge HCLK);
    check("in_even_err", 32'(PARITYERR), 32'h1);
    PARITYSEL = 1'b1;
    @(negedge HCLK);
    check("in_odd_ok", 32'(PARITYERR), 32'h0);
    PARITYSEL = 1'b0;
    @(negedge HCLK);
    check("in_err_again", 32'(PARITYERR), 32'h1);
    ahb_write(8'h04, 32'h1);
    @(negedge HCLK);
    check("out_mode_noerr", 32'(PARITYERR), 32'h0);
    gpio_in_drv = {1'b0, 16'hBEEF};
    @(negedge HCLK);
    ahb_read(8'h00, rd); check("out_mode_rd", rd, 32'h0000_1234);

    // Reset in the middle of a write data phase
    @(negedge HCLK);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HADDR  = 32'h0;
    @(negedge HCLK);
    bus_idle();
    HWDATA  = 32'h0000_BEEF;
    HRESETn = 1'b0;
    #1;
    check("rst_mid_out", 32'(GPIOOUT), 32'h0);
    check("rst_mid_rdy", 32'(HREADYOUT), 32'h1);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("rst_abort", 32'(GPIOOUT), 32'h0);
    ahb_read(8'h04, rd); check("rst_abort_dir", rd, 32'h0);

    // Loopback with random data and parity mode
    gpio_in_drv = 17'h0;
    loop_en     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sel       = 1'($urandom_range(0, 1));
      d         = 16'($urandom);
      PARITYSEL = sel;
      ahb_write(8'h00, {16'h0, d});
      check("lb_out", 32'(GPIOOUT), {15'h0, exp_par(d, sel), d});
      @(negedge HCLK);
      check("lb_noerr", 32'(PARITYERR), 32'h0);
      ahb_read(8'h00, rd); check("lb_rd", rd, {16'h0, d});
      if (i == 10) begin
        ahb_write(8'h08, 32'h0000_A5A5);
        ahb_read(8'h08, rd); check("lb_unmap", rd, 32'h0);
        ahb_read(8'h00, rd); check("lb_unmap_data", rd, {16'h0, d});
      end
    end
    PARITYSEL = ~PARITYSEL;
    @(negedge HCLK);
    check("lb_sel_flip", 32'(PARITYERR), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb_gpio.md
AHB_GPIO -- requirements
Module: ahb_gpio

Interface
REQ-001 Parameter GPIO_W, default 16, GPIO data width; parity adds one bit above it.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 HCLK  in  1  system clock; all state updates on its rising edge.
REQ-004 HRESETn  in  1  asynchronous active-low reset.
REQ-005 HSEL  in  1  slave select.
REQ-006 HADDR  in  32  byte address; only HADDR[7:0] are decoded.
REQ-007 HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ.
REQ-008 HWRITE  in  1  1=write, 0=read.
REQ-009 HREADY  in  1  bus ready; qualifies the address phase.
REQ-010 HREADYOUT  out  1  slave ready; always 1, no wait states.
REQ-011 HWDATA  in  32  write data, valid in the data phase.
REQ-012 HRDATA  out  32  read data, valid in the data phase.
REQ-013 GPIOIN  in  GPIO_W+1  pad input; [GPIO_W-1:0] data, [GPIO_W] parity bit.
REQ-014 GPIOOUT  out  GPIO_W+1  pad output; [GPIO_W-1:0] data, [GPIO_W] parity bit.
REQ-015 PARITYSEL  in  1  1=odd parity, 0=even parity.
REQ-016 PARITYERR  out  1  registered input-parity mismatch flag.

Function
REQ-017 Address phase is accepted when HSEL & HREADY & HTRANS[1]; the block SHALL then register HADDR[7:0], HWRITE and a valid flag for the data phase.
REQ-018 Register map: 0x00 DATA, 0x04 DIR (bit0: 1=output mode, 0=input mode); all other offsets are unmapped.
REQ-019 Write data phase: on the rising edge ending the data phase, the addressed register SHALL load HWDATA; DATA loads HWDATA[GPIO_W-1:0], DIR loads HWDATA[0].
REQ-020 Writes to unmapped offsets SHALL be ignored.
REQ-021 On a DATA write, the output parity bit SHALL be registered from the new data and PARITYSEL sampled in the same cycle.
REQ-022 Parity bit rule: odd parity = ~^data, even parity = ^data, so that data plus parity has the selected count of ones.
REQ-023 GPIOOUT SHALL drive {out_parity, data_out} from registers, independent of DIR.
REQ-024 In input mode (DIR=0), every cycle the block SHALL register GPIOIN[GPIO_W-1:0] into data_in.
REQ-025 In input mode, PARITYERR SHALL register 1 when GPIOIN's parity bit differs from the bit computed from GPIOIN data under the current PARITYSEL, else 0.
REQ-026 In output mode (DIR=1), data_in SHALL hold and PARITYERR SHALL register 0.
REQ-027 Read data phase, DATA offset: HRDATA SHALL be zero-extended data_in when DIR=0, or data_out when DIR=1.
REQ-028 Read data phase, DIR offset: HRDATA = {31'b0, dir}.
REQ-029 Read data phase, unmapped offset or no valid transfer: HRDATA SHALL be 0.
REQ-030 HRDATA SHALL be combinational from the latched address and the registers, giving zero added latency.
REQ-031 Back-to-back transfers: a read of DATA immediately after a DATA write SHALL return the new value when DIR=1.
REQ-032 Transfers with HSEL=0, HREADY=0 or HTRANS IDLE/BUSY SHALL not change any register.

Reset
REQ-033 While HRESETn=0, all of the following SHALL be 0, asynchronously: data_out, out_parity, dir, data_in, PARITYERR, and the address-phase registers.
REQ-034 After reset, GPIOOUT=0 and HRDATA=0; HREADYOUT SHALL be 1 even during reset.
REQ-035 Reset asserted mid-transfer SHALL abort the transfer without a register update.

Structure
REQ-036 A shared package ahb_gpio_pkg SHALL hold GPIO_W, the offsets ADDR_DATA=8'h00 and ADDR_DIR=8'h04, and the parity-mode constants.
REQ-037 One sub-module, gpio_parity, SHALL compute the parity bit from (data, parity_sel); it is used for both generation and checking.

Verification
REQ-038 Reset then read 0x00 and 0x04 -> both 0; GPIOOUT=0; PARITYERR=0.
REQ-039 Write DIR=1, write DATA=0x00A5 with PARITYSEL=0 -> GPIOOUT[15:0]=0x00A5 and GPIOOUT[16]=0 (four ones, even).
REQ-040 Same as REQ-039 with PARITYSEL=1 -> GPIOOUT[16]=1; a read of 0x00 returns 0x000000A5.
REQ-041 DIR=0, drive GPIOIN={1'b1,16'h0001} with PARITYSEL=0 -> PARITYERR=0 next cycle and read 0x00 returns 0x00000001.
REQ-042 DIR=0, drive GPIOIN={1'b0,16'h0001} with PARITYSEL=0 -> PARITYERR=1 next cycle; switching to DIR=1 -> PARITYERR=0.
REQ-043 Loopback GPIOOUT to GPIOIN with random PARITYSEL and 20 random writes and reads, including an unmapped 0x08 access -> no PARITYERR when the select is unchanged, and 0x08 reads 0.
